// File: rtl/singleton_pkg.sv
// Shared widths and FSM state type for the singleton serializer.
package singleton_pkg;

  localparam int unsigned GRAPH_BITS   = 128;
  localparam int unsigned INDEX_BITS   = 7;
  localparam int unsigned ORDINAL_BITS = 6;

  typedef enum logic {IDLE, EMIT} stateT;

endpackage

// File: rtl/bit_select_encoder.sv
// Combinational 128->7 priority encoder: lowest (or highest) set bit plus an exactly-one flag.
module bit_select_encoder
  import singleton_pkg::*;
#(
  parameter bit LOWEST_FIRST = 1'b1
) (
  input  logic [GRAPH_BITS-1:0] vec,
  output logic [INDEX_BITS-1:0] index,
  output logic                  exactlyOne
);

  // Scan toward the preferred end so the last hit is the one that wins.
  always_comb begin
    index = '0;
    if (LOWEST_FIRST) begin
      for (int i = GRAPH_BITS - 1; i >= 0; i--) begin
        if (vec[i]) index = INDEX_BITS'(i);
      end
    end else begin
      for (int i = 0; i < GRAPH_BITS; i++) begin
        if (vec[i]) index = INDEX_BITS'(i);
      end
    end
  end

  assign exactlyOne = ($countones(vec) == 1);

endmodule

// File: rtl/singleton_serializer.sv
// Serializes a 128-bit singleton mask into one beat per set bit, in index order.
// Define SINGLETON_SERIALIZER_EMPTY_BEAT_EN to emit a marker beat for all-zero masks.
module singleton_serializer
  import singleton_pkg::*;
#(
  parameter bit LOWEST_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [GRAPH_BITS-1:0]   singletonsIn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [INDEX_BITS-1:0]   outIndex,
  output logic [ORDINAL_BITS-1:0] outOrdinal,
  output logic                    outLast,
  output logic                    outEmpty
);

  stateT                   stateQ, stateD;
  logic [GRAPH_BITS-1:0]   remainingQ, remainingD;
  logic [ORDINAL_BITS-1:0] ordinalQ, ordinalD;
  logic [INDEX_BITS-1:0]   encIndex;
  logic                    encOne;
  logic                    lastBeat;

  bit_select_encoder #(
    .LOWEST_FIRST(LOWEST_FIRST)
  ) u_encoder (
    .vec       (remainingQ),
    .index     (encIndex),
    .exactlyOne(encOne)
  );

`ifdef SINGLETON_SERIALIZER_EMPTY_BEAT_EN
  logic emptyQ, emptyD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) emptyQ <= 1'b0;
    else     emptyQ <= emptyD;
  end

  // The marker beat has no bits in remaining, so it is last by definition.
  assign lastBeat = encOne || emptyQ;
  assign outEmpty = outValid && emptyQ;
`else
  assign lastBeat = encOne;
  assign outEmpty = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= IDLE;
      remainingQ <= '0;
      ordinalQ   <= '0;
    end else begin
      stateQ     <= stateD;
      remainingQ <= remainingD;
      ordinalQ   <= ordinalD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    remainingD = remainingQ;
    ordinalD   = ordinalQ;
`ifdef SINGLETON_SERIALIZER_EMPTY_BEAT_EN
    emptyD     = emptyQ;
`endif
    unique case (stateQ)
      IDLE: begin
        if (inValid) begin
          if (singletonsIn != '0) begin
            remainingD = singletonsIn;
            ordinalD   = '0;
            stateD     = EMIT;
          end
`ifdef SINGLETON_SERIALIZER_EMPTY_BEAT_EN
          else begin
            remainingD = '0;
            ordinalD   = '0;
            emptyD     = 1'b1;
            stateD     = EMIT;
          end
`endif
        end
      end
      EMIT: begin
        if (outReady) begin
          remainingD[encIndex] = 1'b0;
          ordinalD             = ordinalQ + ORDINAL_BITS'(1);
          if (lastBeat) begin
            stateD = IDLE;
`ifdef SINGLETON_SERIALIZER_EMPTY_BEAT_EN
            emptyD = 1'b0;
`endif
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign inReady    = (stateQ == IDLE);
  assign outValid   = (stateQ == EMIT);
  assign outIndex   = outValid ? encIndex : '0;
  assign outOrdinal = ordinalQ;
  assign outLast    = outValid && lastBeat;

endmodule

// File: tb/tb_singleton_serializer.sv
// Self-checking bench: ascending and descending instances against a queue-based beat model.
module tb_singleton_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inValid = 1'b0;
  logic [127:0] singletonsIn = '0;
  logic         outReady = 1'b1;

  logic       inReadyA, outValidA, outLastA, outEmptyA;
  logic [6:0] outIndexA;
  logic [5:0] outOrdinalA;
  logic       inReadyD, outValidD, outLastD, outEmptyD;
  logic [6:0] outIndexD;
  logic [5:0] outOrdinalD;

  int checks = 0;
  int failures = 0;

  singleton_serializer #(.LOWEST_FIRST(1'b1)) dutA (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReadyA),
    .singletonsIn(singletonsIn), .outValid(outValidA), .outReady(outReady),
    .outIndex(outIndexA), .outOrdinal(outOrdinalA), .outLast(outLastA), .outEmpty(outEmptyA)
  );

  singleton_serializer #(.LOWEST_FIRST(1'b0)) dutD (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReadyD),
    .singletonsIn(singletonsIn), .outValid(outValidD), .outReady(outReady),
    .outIndex(outIndexD), .outOrdinal(outOrdinalD), .outLast(outLastD), .outEmpty(outEmptyD)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ord;
    bit last;
    bit empty;
  } beatT;

  beatT qA[$];
  beatT qD[$];
  bit   expValid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list of a mask: its set bits in index order, numbered from zero.
  task automatic pushMask(input logic [127:0] m);
    int n;
    int k;
    n = $countones(m);
    if (n == 0) begin
`ifdef SINGLETON_SERIALIZER_EMPTY_BEAT_EN
      qA.push_back('{idx: 0, ord: 0, last: 1'b1, empty: 1'b1});
      qD.push_back('{idx: 0, ord: 0, last: 1'b1, empty: 1'b1});
`endif
      return;
    end
    k = 0;
    for (int i = 0; i < 128; i++) begin
      if (m[i]) begin
        qA.push_back('{idx: i, ord: k, last: (k == n - 1), empty: 1'b0});
        k++;
      end
    end
    k = 0;
    for (int i = 127; i >= 0; i--) begin
      if (m[i]) begin
        qD.push_back('{idx: i, ord: k, last: (k == n - 1), empty: 1'b0});
        k++;
      end
    end
  endtask

  // Model steps on the falling edge with inputs that the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      qA.delete();
      qD.delete();
      chk("rstValidA", 32'(outValidA), 32'd0);
      chk("rstValidD", 32'(outValidD), 32'd0);
    end else begin
      expValid = (qA.size() > 0);
      chk("validA", 32'(outValidA), 32'(expValid));
      chk("validD", 32'(outValidD), 32'(qD.size() > 0));
      chk("inReadyA", 32'(inReadyA), 32'(!expValid));
      chk("inReadyD", 32'(inReadyD), 32'(!expValid));
      if (expValid && outValidA) begin
        chk("idxA", 32'(outIndexA), 32'(qA[0].idx));
        chk("ordA", 32'(outOrdinalA), 32'(qA[0].ord % 64));
        chk("lastA", 32'(outLastA), 32'(qA[0].last));
        chk("emptyA", 32'(outEmptyA), 32'(qA[0].empty));
      end
      if (qD.size() > 0 && outValidD) begin
        chk("idxD", 32'(outIndexD), 32'(qD[0].idx));
        chk("ordD", 32'(outOrdinalD), 32'(qD[0].ord % 64));
        chk("lastD", 32'(outLastD), 32'(qD[0].last));
        chk("emptyD", 32'(outEmptyD), 32'(qD[0].empty));
      end
      if (expValid) begin
        if (outReady) begin
          void'(qA.pop_front());
          if (qD.size() > 0) void'(qD.pop_front());
        end
      end else if (inValid) begin
        pushMask(singletonsIn);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic accept(input logic [127:0] m);
    int t;
    t = 0;
    while (!inReadyA && t < 300) begin
      cyc();
      t++;
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL acceptTimeout: inReady stayed %0d, expected 1", inReadyA);
    end
    inValid = 1'b1;
    singletonsIn = m;
    cyc();
    inValid = 1'b0;
    singletonsIn = junk();
  endtask

  logic [127:0] m;
  int n;
  int t;

  initial begin
    #1 rst = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rstInReady", 32'(inReadyA), 32'd1);
    chk("rstIndex", 32'(outIndexA), 32'd0);
    chk("rstOrdinal", 32'(outOrdinalA), 32'd0);
    chk("rstLast", 32'(outLastA), 32'd0);
    chk("rstEmpty", 32'(outEmptyA), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("postRstReady", 32'(inReadyA), 32'd1);
    cyc();

    // Three-bit mask in both orders at full throughput.
    m = '0; m[3] = 1'b1; m[40] = 1'b1; m[127] = 1'b1;
    accept(m);
    @(negedge clk);
    chk("d026idx0A", 32'(outIndexA), 32'd3);
    chk("d026ord0A", 32'(outOrdinalA), 32'd0);
    chk("d026last0A", 32'(outLastA), 32'd0);
    chk("d027idx0D", 32'(outIndexD), 32'd127);
    @(negedge clk);
    chk("d026idx1A", 32'(outIndexA), 32'd40);
    chk("d026ord1A", 32'(outOrdinalA), 32'd1);
    chk("d027idx1D", 32'(outIndexD), 32'd40);
    @(negedge clk);
    chk("d026idx2A", 32'(outIndexA), 32'd127);
    chk("d026last2A", 32'(outLastA), 32'd1);
    chk("d027idx2D", 32'(outIndexD), 32'd3);
    chk("d027last2D", 32'(outLastD), 32'd1);
    @(negedge clk);
    chk("d026readyAfter", 32'(inReadyA), 32'd1);
    cyc();

    // Stall on the first beat.
    m = '0; m[5] = 1'b1; m[9] = 1'b1;
    outReady = 1'b0;
    accept(m);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d028holdIdx", 32'(outIndexA), 32'd5);
      chk("d028holdValid", 32'(outValidA), 32'd1);
      chk("d028holdOrd", 32'(outOrdinalA), 32'd0);
    end
    cyc();
    outReady = 1'b1;
    @(negedge clk);
    chk("d028idx0", 32'(outIndexA), 32'd5);
    @(negedge clk);
    chk("d028idx1", 32'(outIndexA), 32'd9);
    chk("d028last1", 32'(outLastA), 32'd1);
    cyc();

    // All-zero mask.
    accept('0);
    @(negedge clk);
`ifdef SINGLETON_SERIALIZER_EMPTY_BEAT_EN
    chk("d029valid", 32'(outValidA), 32'd1);
    chk("d029empty", 32'(outEmptyA), 32'd1);
    chk("d029last", 32'(outLastA), 32'd1);
    chk("d029idx", 32'(outIndexA), 32'd0);
`else
    chk("d029valid", 32'(outValidA), 32'd0);
    chk("d029ready", 32'(inReadyA), 32'd1);
    chk("d029empty", 32'(outEmptyA), 32'd0);
`endif
    cyc();

    // Every weight-3 vertex of the 7-cube.
    m = '0;
    for (int i = 0; i < 128; i++) begin
      if ($countones(7'(i)) == 3) m[i] = 1'b1;
    end
    accept(m);
    n = 0;
    t = 0;
    @(negedge clk);
    while (outValidA && t < 100) begin
      n++;
      t++;
      @(negedge clk);
    end
    chk("d030beats", 32'(n), 32'd35);
    cyc();

    // Asynchronous reset in the middle of a mask.
    m = '0; m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1;
    accept(m);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("d031validAsync", 32'(outValidA), 32'd0);
    chk("d031lastAsync", 32'(outLastA), 32'd0);
    chk("d031idxAsync", 32'(outIndexA), 32'd0);
    chk("d031ordAsync", 32'(outOrdinalA), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("d031readyAfter", 32'(inReadyA), 32'd1);
    cyc();
    m = '0; m[10] = 1'b1; m[20] = 1'b1;
    accept(m);
    @(negedge clk);
    chk("d031ord0", 32'(outOrdinalA), 32'd0);
    chk("d031idx0", 32'(outIndexA), 32'd10);
    cyc();

    // Randomized traffic with random backpressure and junk on idle inputs.
    for (int c = 0; c < 4000; c++) begin
      outReady = ($urandom % 4) != 0;
      if ($urandom % 3 == 0) begin
        m = '0;
        repeat ($urandom % 6) m[$urandom % 128] = 1'b1;
        inValid = 1'b1;
        singletonsIn = m;
      end else begin
        inValid = 1'b0;
        singletonsIn = junk();
      end
      cyc();
    end
    inValid = 1'b0;
    outReady = 1'b1;
    t = 0;
    while (qA.size() > 0 && t < 200) begin
      cyc();
      t++;
    end
    chk("drainDone", 32'(qA.size()), 32'd0);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
